// File: rtl/isq_pkg.sv
// Shared widths, line layout and helpers for the issue queue.
package isq_pkg;

    localparam int ISQ_DEPTH        = 64;
    localparam int INST_WIDTH       = 56;
    localparam int ISQ_IDX_BITS_NUM = 6;
    localparam int ISQ_LINE_WIDTH   = INST_WIDTH + ISQ_IDX_BITS_NUM + 2;
    localparam int DSP_LANES        = 4;

    // Field positions inside one presented line: idx | wat | vld | inst.
    localparam int ISQ_BIT_IDX = 63;
    localparam int ISQ_BIT_WAT = 57;
    localparam int ISQ_BIT_VLD = 56;

    localparam int ISQ_CNT_WIDTH = 7;

    typedef logic [ISQ_IDX_BITS_NUM-1:0] isq_idx_t;
    typedef logic [ISQ_CNT_WIDTH-1:0]    isq_cnt_t;
    typedef logic [ISQ_DEPTH-1:0]        isq_vec_t;

    // Number of set bits in a line vector.
    function automatic isq_cnt_t isq_popcnt(input isq_vec_t v);
        isq_cnt_t c;
        c = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            c = c + isq_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/isq_alc.sv
// Combinational allocator: lane k is granted the k-th lowest free line.
module isq_alc
    import isq_pkg::*;
(
    input  logic [ISQ_DEPTH-1:0]           free_vec,
    output logic [DSP_LANES*ISQ_DEPTH-1:0] gnt_flat,
    output logic [DSP_LANES-1:0]           gnt_vld
);

    logic [ISQ_DEPTH-1:0] rem;
    logic [ISQ_DEPTH-1:0] one;

    // Chained lowest-set-bit find; each grant is masked out before the next lane looks.
    always_comb begin
        rem      = free_vec;
        one      = '0;
        gnt_flat = '0;
        gnt_vld  = '0;
        for (int k = 0; k < DSP_LANES; k++) begin
            one                                  = rem & (-rem);
            gnt_flat[k*ISQ_DEPTH +: ISQ_DEPTH]   = one;
            gnt_vld[k]                           = |rem;
            rem                                  = rem & ~one;
        end
    end

endmodule

// File: rtl/isq_ctl.sv
// Issue-queue line storage: dispatch allocation, issue clear/free and branch squash.
module isq_ctl
    import isq_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DSP_LANES*INST_WIDTH-1:0]     dsp_ins_flat,
    input  logic [DSP_LANES-1:0]                dsp_ins_vld,
    input  logic [DSP_LANES-1:0]                dsp_brn_wat,
    input  logic [ISQ_DEPTH-1:0]                pdc_clr_inst_wat,
    input  logic                                brn_rsv_vld,
    input  logic                                brn_mis_prd,
    output logic [ISQ_DEPTH*ISQ_LINE_WIDTH-1:0] isq_lin_flat,
    output logic [ISQ_DEPTH-1:0]                isq_brn_wat,
    output logic                                isq_ful,
    output logic [ISQ_CNT_WIDTH-1:0]            isq_cnt
);

    logic [ISQ_DEPTH-1:0]  vld_q, wat_q, brn_q;
    logic [ISQ_DEPTH-1:0]  vld_d, wat_d, brn_d;
    logic [INST_WIDTH-1:0] inst_q [ISQ_DEPTH];
    logic [INST_WIDTH-1:0] inst_d [ISQ_DEPTH];

    logic [DSP_LANES*ISQ_DEPTH-1:0] gnt_flat;
    logic [DSP_LANES-1:0]           gnt_vld;
    logic [DSP_LANES-1:0]           lane_wr;

    isq_alc u_alc (
        .free_vec (~vld_q),
        .gnt_flat (gnt_flat),
        .gnt_vld  (gnt_vld)
    );

    // A lane writes only if it is valid, found a free line, and no squash is in progress.
    assign lane_wr = brn_mis_prd ? '0 : (dsp_ins_vld & gnt_vld);

    // Per-line next state: mispredict squash, then clear/free of live lines, then allocation into free lines.
    always_comb begin
        vld_d  = vld_q;
        wat_d  = wat_q;
        brn_d  = brn_q;
        inst_d = inst_q;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            if (brn_mis_prd && brn_q[i]) begin
                vld_d[i] = 1'b0;
                wat_d[i] = 1'b0;
                brn_d[i] = 1'b0;
            end else if (vld_q[i]) begin
                if (!wat_q[i]) begin
                    // Issued last cycle: release the line and its speculative tag together.
                    vld_d[i] = 1'b0;
                    brn_d[i] = 1'b0;
                end else if (pdc_clr_inst_wat[i]) begin
                    wat_d[i] = 1'b0;
                end
                if (brn_rsv_vld) begin
                    brn_d[i] = 1'b0;
                end
            end else begin
                for (int k = 0; k < DSP_LANES; k++) begin
                    if (lane_wr[k] && gnt_flat[k*ISQ_DEPTH + i]) begin
                        vld_d[i]  = 1'b1;
                        wat_d[i]  = 1'b1;
                        brn_d[i]  = dsp_brn_wat[k] & ~brn_rsv_vld;
                        inst_d[i] = dsp_ins_flat[k*INST_WIDTH +: INST_WIDTH];
                    end
                end
            end
        end
    end

    // Line registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            wat_q <= '0;
            brn_q <= '0;
            for (int i = 0; i < ISQ_DEPTH; i++) begin
                inst_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            wat_q  <= wat_d;
            brn_q  <= brn_d;
            inst_q <= inst_d;
        end
    end

    // Flatten registered lines; idx is the constant line number.
    for (genvar g = 0; g < ISQ_DEPTH; g++) begin : g_line
        assign isq_lin_flat[g*ISQ_LINE_WIDTH + ISQ_BIT_IDX -: ISQ_IDX_BITS_NUM] = isq_idx_t'(g);
        assign isq_lin_flat[g*ISQ_LINE_WIDTH + ISQ_BIT_WAT]                    = wat_q[g];
        assign isq_lin_flat[g*ISQ_LINE_WIDTH + ISQ_BIT_VLD]                    = vld_q[g];
        assign isq_lin_flat[g*ISQ_LINE_WIDTH +: INST_WIDTH]                    = inst_q[g];
    end

    assign isq_brn_wat = brn_q;
    assign isq_cnt     = isq_popcnt(vld_q);
    // Full means a 4-lane dispatch would not fit.
    assign isq_ful     = (isq_cnt_t'(ISQ_DEPTH) - isq_cnt) < isq_cnt_t'(DSP_LANES);

endmodule

// File: tb/tb_isq_ctl.sv
// Directed bench for isq_ctl: allocation, full boundary, issue clear, squash, resolve, reset.
module tb_isq_ctl;
    import isq_pkg::*;

    logic                                clk = 1'b0;
    logic                                rst_n = 1'b0;
    logic [DSP_LANES*INST_WIDTH-1:0]     dsp_ins_flat = '0;
    logic [DSP_LANES-1:0]                dsp_ins_vld = '0;
    logic [DSP_LANES-1:0]                dsp_brn_wat = '0;
    logic [ISQ_DEPTH-1:0]                pdc_clr_inst_wat = '0;
    logic                                brn_rsv_vld = 1'b0;
    logic                                brn_mis_prd = 1'b0;
    logic [ISQ_DEPTH*ISQ_LINE_WIDTH-1:0] isq_lin_flat;
    logic [ISQ_DEPTH-1:0]                isq_brn_wat;
    logic                                isq_ful;
    logic [ISQ_CNT_WIDTH-1:0]            isq_cnt;

    isq_ctl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dsp_ins_flat     (dsp_ins_flat),
        .dsp_ins_vld      (dsp_ins_vld),
        .dsp_brn_wat      (dsp_brn_wat),
        .pdc_clr_inst_wat (pdc_clr_inst_wat),
        .brn_rsv_vld      (brn_rsv_vld),
        .brn_mis_prd      (brn_mis_prd),
        .isq_lin_flat     (isq_lin_flat),
        .isq_brn_wat      (isq_brn_wat),
        .isq_ful          (isq_ful),
        .isq_cnt          (isq_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int seq   = 0;

    logic [ISQ_DEPTH-1:0]  exp_vld;
    logic [ISQ_DEPTH-1:0]  exp_wat;
    logic [INST_WIDTH-1:0] exp_inst [ISQ_DEPTH];

    function automatic logic [INST_WIDTH-1:0] pay(input int n);
        return {8'hC3, 16'h0, 32'(n) * 32'h0000_9E37 + 32'h11};
    endfunction

    function automatic logic [ISQ_LINE_WIDTH-1:0] line_of(input int i);
        return isq_lin_flat[i*ISQ_LINE_WIDTH +: ISQ_LINE_WIDTH];
    endfunction

    function automatic logic [ISQ_LINE_WIDTH-1:0] exp_line(input int i);
        return {isq_idx_t'(i), exp_wat[i], exp_vld[i], exp_inst[i]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dsp_ins_flat     = '0;
        dsp_ins_vld      = '0;
        dsp_brn_wat      = '0;
        pdc_clr_inst_wat = '0;
        brn_rsv_vld      = 1'b0;
        brn_mis_prd      = 1'b0;
    endtask

    task automatic drive(input int lanes, input logic brn);
        dsp_ins_flat = '0;
        dsp_ins_vld  = '0;
        dsp_brn_wat  = '0;
        for (int k = 0; k < lanes; k++) begin
            dsp_ins_vld[k] = 1'b1;
            dsp_brn_wat[k] = brn;
            dsp_ins_flat[k*INST_WIDTH +: INST_WIDTH] = pay(seq + k);
        end
    endtask

    task automatic note(input int line, input int k);
        exp_vld[line]  = 1'b1;
        exp_wat[line]  = 1'b1;
        exp_inst[line] = pay(seq + k);
    endtask

    task automatic model_clear();
        exp_vld = '0;
        exp_wat = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) exp_inst[i] = '0;
    endtask

    task automatic test_reset();
        logic [ISQ_LINE_WIDTH-1:0] want;
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_clear();
        n_cmp++; if (isq_cnt !== 7'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", isq_cnt); end
        n_cmp++; if (isq_ful !== 1'b0) begin n_bad++; $display("FAIL reset_ful got %b want 0", isq_ful); end
        n_cmp++; if (isq_brn_wat !== 64'h0) begin n_bad++; $display("FAIL reset_brn got %h want 0", isq_brn_wat); end
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            want = {isq_idx_t'(i), 58'h0};
            n_cmp++;
            if (line_of(i) !== want) begin n_bad++; $display("FAIL reset_line%0d got %h want %h", i, line_of(i), want); end
        end
    endtask

    task automatic test_dispatch();
        drive(4, 1'b0);
        for (int k = 0; k < 4; k++) note(k, k);
        step();
        seq += 4;
        idle();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (line_of(i) !== exp_line(i)) begin n_bad++; $display("FAIL disp_line%0d got %h want %h", i, line_of(i), exp_line(i)); end
        end
        n_cmp++; if (isq_cnt !== 7'd4) begin n_bad++; $display("FAIL disp_cnt got %0d want 4", isq_cnt); end
        n_cmp++; if (isq_ful !== 1'b0) begin n_bad++; $display("FAIL disp_ful got %b want 0", isq_ful); end
    endtask

    task automatic test_full();
        for (int c = 1; c < 15; c++) begin
            drive(4, 1'b0);
            for (int k = 0; k < 4; k++) note(4*c + k, k);
            step();
            seq += 4;
        end
        idle();
        n_cmp++; if (isq_cnt !== 7'd60) begin n_bad++; $display("FAIL full60_cnt got %0d want 60", isq_cnt); end
        n_cmp++; if (isq_ful !== 1'b0) begin n_bad++; $display("FAIL full60_ful got %b want 0", isq_ful); end
        drive(4, 1'b0);
        for (int k = 0; k < 4; k++) note(60 + k, k);
        step();
        seq += 4;
        idle();
        n_cmp++; if (isq_cnt !== 7'd64) begin n_bad++; $display("FAIL full64_cnt got %0d want 64", isq_cnt); end
        n_cmp++; if (isq_ful !== 1'b1) begin n_bad++; $display("FAIL full64_ful got %b want 1", isq_ful); end
        drive(4, 1'b0);
        step();
        seq += 4;
        idle();
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            n_cmp++;
            if (line_of(i) !== exp_line(i)) begin n_bad++; $display("FAIL ovf_line%0d got %h want %h", i, line_of(i), exp_line(i)); end
        end
        n_cmp++; if (isq_cnt !== 7'd64) begin n_bad++; $display("FAIL ovf_cnt got %0d want 64", isq_cnt); end
    endtask

    task automatic test_clear();
        pdc_clr_inst_wat[2] = 1'b1;
        pdc_clr_inst_wat[5] = 1'b1;
        step();
        idle();
        exp_wat[2] = 1'b0;
        exp_wat[5] = 1'b0;
        n_cmp++; if (line_of(2) !== exp_line(2)) begin n_bad++; $display("FAIL clr_n1_line2 got %h want %h", line_of(2), exp_line(2)); end
        n_cmp++; if (line_of(5) !== exp_line(5)) begin n_bad++; $display("FAIL clr_n1_line5 got %h want %h", line_of(5), exp_line(5)); end
        n_cmp++; if (isq_cnt !== 7'd64) begin n_bad++; $display("FAIL clr_n1_cnt got %0d want 64", isq_cnt); end
        step();
        exp_vld[2] = 1'b0;
        exp_vld[5] = 1'b0;
        n_cmp++; if (line_of(2)[63:56] !== exp_line(2)[63:56]) begin n_bad++; $display("FAIL clr_n2_line2 got %h want %h", line_of(2)[63:56], exp_line(2)[63:56]); end
        n_cmp++; if (line_of(5)[63:56] !== exp_line(5)[63:56]) begin n_bad++; $display("FAIL clr_n2_line5 got %h want %h", line_of(5)[63:56], exp_line(5)[63:56]); end
        n_cmp++; if (isq_cnt !== 7'd62) begin n_bad++; $display("FAIL clr_n2_cnt got %0d want 62", isq_cnt); end
        n_cmp++; if (isq_ful !== 1'b1) begin n_bad++; $display("FAIL clr_n2_ful got %b want 1", isq_ful); end
        drive(2, 1'b0);
        note(2, 0);
        note(5, 1);
        step();
        seq += 2;
        idle();
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            n_cmp++;
            if (line_of(i) !== exp_line(i)) begin n_bad++; $display("FAIL realloc_line%0d got %h want %h", i, line_of(i), exp_line(i)); end
        end
        n_cmp++; if (isq_cnt !== 7'd64) begin n_bad++; $display("FAIL realloc_cnt got %0d want 64", isq_cnt); end
    endtask

    task automatic test_mispredict();
        logic [ISQ_LINE_WIDTH-1:0] got, want;
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_clear();
        drive(4, 1'b0); for (int k = 0; k < 4; k++) note(k, k);      step(); seq += 4;
        drive(4, 1'b0); for (int k = 0; k < 4; k++) note(4 + k, k);  step(); seq += 4;
        drive(2, 1'b0); for (int k = 0; k < 2; k++) note(8 + k, k);  step(); seq += 2;
        drive(4, 1'b1); for (int k = 0; k < 4; k++) note(10 + k, k); step(); seq += 4;
        idle();
        n_cmp++; if (isq_brn_wat !== 64'h3C00) begin n_bad++; $display("FAIL mis_pre_brn got %h want 3c00", isq_brn_wat); end
        n_cmp++; if (isq_cnt !== 7'd14) begin n_bad++; $display("FAIL mis_pre_cnt got %0d want 14", isq_cnt); end
        drive(2, 1'b0);
        brn_mis_prd = 1'b1;
        pdc_clr_inst_wat[3] = 1'b1;
        step();
        seq += 2;
        idle();
        for (int i = 10; i < 14; i++) begin
            exp_vld[i] = 1'b0;
            exp_wat[i] = 1'b0;
        end
        exp_wat[3] = 1'b0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            got  = line_of(i);
            want = exp_line(i);
            if (!exp_vld[i]) begin
                got[INST_WIDTH-1:0]  = '0;
                want[INST_WIDTH-1:0] = '0;
            end
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL mis_line%0d got %h want %h", i, got, want); end
        end
        n_cmp++; if (isq_cnt !== 7'd10) begin n_bad++; $display("FAIL mis_cnt got %0d want 10", isq_cnt); end
        n_cmp++; if (isq_brn_wat !== 64'h0) begin n_bad++; $display("FAIL mis_brn got %h want 0", isq_brn_wat); end
        step();
        exp_vld[3] = 1'b0;
        n_cmp++; if (isq_cnt !== 7'd9) begin n_bad++; $display("FAIL mis_free_cnt got %0d want 9", isq_cnt); end
        n_cmp++; if (line_of(3)[63:56] !== exp_line(3)[63:56]) begin n_bad++; $display("FAIL mis_free_line3 got %h want %h", line_of(3)[63:56], exp_line(3)[63:56]); end
    endtask

    task automatic test_resolve();
        drive(4, 1'b1);
        note(3, 0); note(10, 1); note(11, 2); note(12, 3);
        step();
        seq += 4;
        idle();
        n_cmp++; if (isq_brn_wat !== 64'h1C08) begin n_bad++; $display("FAIL rsv_pre_brn got %h want 1c08", isq_brn_wat); end
        drive(2, 1'b1);
        brn_rsv_vld = 1'b1;
        note(13, 0); note(14, 1);
        step();
        seq += 2;
        idle();
        n_cmp++; if (isq_brn_wat !== 64'h0) begin n_bad++; $display("FAIL rsv_brn got %h want 0", isq_brn_wat); end
        n_cmp++; if (isq_cnt !== 7'd15) begin n_bad++; $display("FAIL rsv_cnt got %0d want 15", isq_cnt); end
        for (int i = 10; i < 16; i++) begin
            n_cmp++;
            if (line_of(i) !== exp_line(i)) begin n_bad++; $display("FAIL rsv_line%0d got %h want %h", i, line_of(i), exp_line(i)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [ISQ_LINE_WIDTH-1:0] want;
        drive(4, 1'b1);
        pdc_clr_inst_wat = 64'h0000_0000_0000_00FF;
        rst_n = 1'b0;
        step();
        idle();
        n_cmp++; if (isq_cnt !== 7'd0) begin n_bad++; $display("FAIL rmid_cnt got %0d want 0", isq_cnt); end
        n_cmp++; if (isq_ful !== 1'b0) begin n_bad++; $display("FAIL rmid_ful got %b want 0", isq_ful); end
        n_cmp++; if (isq_brn_wat !== 64'h0) begin n_bad++; $display("FAIL rmid_brn got %h want 0", isq_brn_wat); end
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            want = {isq_idx_t'(i), 58'h0};
            n_cmp++;
            if (line_of(i) !== want) begin n_bad++; $display("FAIL rmid_line%0d got %h want %h", i, line_of(i), want); end
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_dispatch();
        test_full();
        test_clear();
        test_mispredict();
        test_resolve();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
